// File: rtl/nota_pkg.sv
// Shared constants for the note detector: note codes, nominal period table, FSM states.
package nota_pkg;

  localparam int unsigned PERIOD_W   = 18;
  localparam int unsigned NOTE_W     = 4;
  localparam int unsigned NUM_NOTES  = 13;
  localparam int unsigned REF_CLK_HZ = 50_000_000;

  localparam logic [NOTE_W-1:0] DOO           = 4'd0;
  localparam logic [NOTE_W-1:0] DO_GRANDE     = 4'd1;
  localparam logic [NOTE_W-1:0] DO_SOS        = 4'd2;
  localparam logic [NOTE_W-1:0] FA_SOS        = 4'd3;
  localparam logic [NOTE_W-1:0] LA            = 4'd4;
  localparam logic [NOTE_W-1:0] LA_SOS        = 4'd5;
  localparam logic [NOTE_W-1:0] MI            = 4'd6;
  localparam logic [NOTE_W-1:0] MI_GRANDE     = 4'd7;
  localparam logic [NOTE_W-1:0] RE            = 4'd8;
  localparam logic [NOTE_W-1:0] RE_SOS        = 4'd9;
  localparam logic [NOTE_W-1:0] RE_SOS_GRANDE = 4'd10;
  localparam logic [NOTE_W-1:0] SI            = 4'd11;
  localparam logic [NOTE_W-1:0] SOL           = 4'd12;
  localparam logic [NOTE_W-1:0] SILENCIO      = 4'd13;

  // Nominal periods in cycles of a REF_CLK_HZ clock, indexed by note code.
  localparam int unsigned NOM_PERIOD [0:NUM_NOTES-1] = '{
    191113, 95556, 180388, 135139,
    113636, 107259, 151686, 75842,
    170264, 160705, 80353, 101239,
    127551
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_MEASURE
  } state_e;

  // Rescales the reference table to the actual clock, rounding to nearest.
  function automatic logic [PERIOD_W-1:0] nom_period(input logic [NOTE_W-1:0] k,
                                                     input int unsigned clk_hz);
    longint unsigned num;
    num = 64'(NOM_PERIOD[k]) * 64'(clk_hz) + 64'(REF_CLK_HZ / 2);
    return PERIOD_W'(num / 64'(REF_CLK_HZ));
  endfunction

endpackage

// File: rtl/detector_nota_clasificador_periodo.sv
// Combinational period classifier: compares a period against the 13 note windows.
module clasificador_periodo
  import nota_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter int unsigned TOL_SHIFT = 6
) (
  input  logic [PERIOD_W-1:0] periodo_i,
  output logic [NOTE_W-1:0]   clase_c_o,
  output logic                hit_c_o
);

  logic [NUM_NOTES-1:0] match;

  for (genvar g = 0; g < NUM_NOTES; g++) begin : g_win
    localparam logic [PERIOD_W-1:0] NOM = nom_period(NOTE_W'(g), CLK_HZ);
    localparam logic [PERIOD_W-1:0] TOL = NOM >> TOL_SHIFT;
    logic [PERIOD_W-1:0] diff;
    assign diff     = (periodo_i >= NOM) ? (periodo_i - NOM) : (NOM - periodo_i);
    assign match[g] = (diff <= TOL);
  end

  // Windows are disjoint, so at most one match bit is set.
  always_comb begin
    clase_c_o = SILENCIO;
    hit_c_o   = 1'b0;
    for (int k = 0; k < int'(NUM_NOTES); k++) begin
      if (match[k]) begin
        clase_c_o = NOTE_W'(k);
        hit_c_o   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/detector_nota.sv
// Measures the period of a square-wave note input and reports a confirmed note code.
module detector_nota
  import nota_pkg::*;
#(
  parameter int unsigned CLK_HZ         = 50_000_000,
  parameter int unsigned TOL_SHIFT      = 6,
  parameter int unsigned CONFIRM        = 2,
  parameter int unsigned SILENCE_CYCLES = 250_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                nota_in,
  output logic [NOTE_W-1:0]   nota_idx,
  output logic                nota_valid,
  output logic [PERIOD_W-1:0] periodo,
  output logic                locked
);

  localparam logic [PERIOD_W-1:0] CNT_MAX   = '1;
  localparam logic [PERIOD_W-1:0] SIL_LIMIT = PERIOD_W'(SILENCE_CYCLES);
  localparam logic [2:0]          CONFIRM_C = 3'(CONFIRM);

  state_e              state_q;
  logic [2:0]          sync_q;
  logic [PERIOD_W-1:0] cnt_q;
  logic [PERIOD_W-1:0] cnt_d;
  logic [NOTE_W-1:0]   cand_q;
  logic [NOTE_W-1:0]   cand_d;
  logic [2:0]          cand_cnt_q;
  logic [2:0]          cand_cnt_d;

  logic                edge_c;
  logic                silence_c;
  logic [PERIOD_W-1:0] per_c;
  logic [NOTE_W-1:0]   clase_c;
  logic                hit_c;
  logic                commit_c;
  logic [NOTE_W-1:0]   idx_next_c;
  logic                locked_next_c;

  // sync_q[1:0] is the synchronizer, sync_q[2] the previous value for edge detection.
  assign edge_c    = sync_q[1] & ~sync_q[2];
  assign silence_c = ~edge_c & (cnt_q == SIL_LIMIT);
  assign per_c     = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + PERIOD_W'(1);

  always_comb begin
    cnt_d = cnt_q;
    if (edge_c) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + PERIOD_W'(1);
    end
  end

  clasificador_periodo #(
    .CLK_HZ   (CLK_HZ),
    .TOL_SHIFT(TOL_SHIFT)
  ) u_clasificador (
    .periodo_i(per_c),
    .clase_c_o(clase_c),
    .hit_c_o  (hit_c)
  );

  // Candidate tracking: consecutive matching periods build confidence, unknown resets it.
  always_comb begin
    cand_d     = cand_q;
    cand_cnt_d = cand_cnt_q;
    if (hit_c) begin
      if (clase_c == cand_q) begin
        if (cand_cnt_q < CONFIRM_C) cand_cnt_d = cand_cnt_q + 3'd1;
      end else begin
        cand_d     = clase_c;
        cand_cnt_d = 3'd1;
      end
    end else begin
      cand_cnt_d = '0;
    end
    commit_c      = hit_c && (cand_cnt_d == CONFIRM_C) && (cand_d != nota_idx);
    idx_next_c    = commit_c ? cand_d : nota_idx;
    locked_next_c = hit_c && (clase_c == idx_next_c);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      sync_q     <= '0;
      cnt_q      <= '0;
      cand_q     <= SILENCIO;
      cand_cnt_q <= '0;
      nota_idx   <= SILENCIO;
      nota_valid <= 1'b0;
      periodo    <= '0;
      locked     <= 1'b0;
    end else begin
      sync_q     <= {sync_q[1:0], nota_in};
      cnt_q      <= cnt_d;
      nota_valid <= 1'b0;
      if (edge_c) begin
        case (state_q)
          ST_IDLE: state_q <= ST_ARMED;
          ST_ARMED, ST_MEASURE: begin
            state_q    <= ST_MEASURE;
            periodo    <= per_c;
            cand_q     <= cand_d;
            cand_cnt_q <= cand_cnt_d;
            locked     <= locked_next_c;
            if (commit_c) begin
              nota_idx   <= cand_d;
              nota_valid <= 1'b1;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end else if (silence_c) begin
        // Edge has priority; silence only when the count expires on a quiet cycle.
        state_q    <= ST_IDLE;
        cand_q     <= SILENCIO;
        cand_cnt_q <= '0;
        locked     <= 1'b0;
        nota_idx   <= SILENCIO;
        nota_valid <= (nota_idx != SILENCIO);
      end
    end
  end

endmodule

// File: doc/detector_nota.md
# detector_nota

Receive-side counterpart of the tone sequencer: it takes a one-bit square-wave note signal (the `nota` line), measures its period in `clk` cycles, and classifies it into one of the 14 note codes used by the player. A change is reported only after it has been confirmed over consecutive periods. The block sits on the audio input path of the board, for example looping the player output back for self-test or decoding an external tone source. It drives the display and logging logic with a stable note index.

## Interface
- `CLK_HZ`, default 50_000_000: clock frequency. The nominal period table is computed for this value.
- `TOL_SHIFT`, default 6: match window is nominal ± (nominal >> TOL_SHIFT), which is ±1.56 %.
- `CONFIRM`, default 2: number of consecutive periods that must classify to the same note before the output changes (range 1–7).
- `SILENCE_CYCLES`, default 250_000: the output is forced to silence after this many cycles with no rising edge (5 ms).
- `clk` in 1: single clock. All logic is on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `nota_in` in 1: square-wave input, asynchronous to `clk`.
- `nota_idx` out 4: current note code, 0–13.
- `nota_valid` out 1: one-cycle pulse whenever `nota_idx` changes value.
- `periodo` out 18: last measured period, in cycles.
- `locked` out 1: 1 when the last classified period matched `nota_idx`.

## Operation
- Note codes (fixed): 0 doo, 1 do_grande, 2 do_sos, 3 fa_sos, 4 la, 5 la_sos, 6 mi, 7 mi_grande, 8 re, 9 re_sos, 10 re_sos_grande, 11 si, 12 sol, 13 silencio.
- Nominal periods at 50 MHz, as round(CLK_HZ/f):
  - doo 191113, do_grande 95556, do_sos 180388, fa_sos 135139
  - la 113636, la_sos 107259, mi 151686, mi_grande 75842
  - re 170264, re_sos 160705, re_sos_grande 80353, si 101239, sol 127551.
- Input path: 2-flop synchronizer, then a rising-edge detector. The detector fires one cycle per input rising edge.
- Period counter `cnt`, 18 bits:
  - Cleared to 0 on an edge cycle; otherwise increments, saturating at 2^18−1.
  - On an edge, `periodo` ← `cnt`+1, so an input of period P cycles yields exactly P.
- Classification: a period matches note k when |P − nom_k| ≤ nom_k >> TOL_SHIFT, inclusive at both bounds. The windows do not overlap; no match means "unknown".
- FSM states:
  - IDLE: no reference edge. First edge → ARMED; no period is captured.
  - ARMED: next edge captures the first period → MEASURE.
  - MEASURE: on each edge, classify the period:
    - Same as the candidate: `cand_cnt`++, saturating at CONFIRM.
    - Different known note: candidate ← that note, `cand_cnt` ← 1.
    - Unknown: `cand_cnt` ← 0.
    - Commit: when `cand_cnt` reaches CONFIRM and the candidate ≠ `nota_idx`, load `nota_idx` and pulse `nota_valid` on the next cycle.
  - Any state: if `cnt` reaches SILENCE_CYCLES with no edge, go to IDLE, clear the candidate and `locked`, and set `nota_idx` ← 13. `nota_valid` pulses only if the previous value was not 13.
- `locked` is updated on every classified edge: 1 if the class equals `nota_idx` after the update, else 0.

## Timing
- Reset values: `nota_idx`=13, `nota_valid`=0, `periodo`=0, `locked`=0, FSM=IDLE, `cnt`=0, candidate cleared.
- Edge latency: an input rising edge is detected 3 `clk` cycles later (2 synchronizer + 1 detect).
- Output latency: `nota_idx` and `nota_valid` update 1 cycle after the edge that completes confirmation. `periodo` updates on the edge cycle itself.
- From silence, the first commit happens on edge number CONFIRM+1 (default: the 3rd rising edge).
- An edge and a silence timeout in the same cycle: the edge wins and silence is not declared.
- `rst` asserted mid-measurement: all state returns to reset values on the next clock; partial periods are discarded.
- At most one `nota_valid` pulse per input period.

## Structure
- Package `nota_pkg`: note-code localparams 0–13, the `NOM_PERIOD[0:12]` constant array (derived from CLK_HZ), and the period width (18).
- Sub-module `clasificador_periodo`: purely combinational; 18-bit period in, 4-bit class out plus a hit flag. It holds the 13 window compares.
- The top level holds the synchronizer, edge detect, counter, FSM, and confirmation logic.

## Test plan
- After reset, drive a square wave of period 113636: `nota_idx`=4 and one `nota_valid` pulse 1 cycle after the 3rd detected rising edge; `periodo`=113636.
- Switch the input to period 127551: after 2 more periods, `nota_idx`=12 and a single pulse; `locked` reads 0 on the first sol edge and 1 after the commit.
- Hold `nota_in` low for 250_000 cycles while locked on la: `nota_idx`=13, one pulse, FSM returns to IDLE; the next single edge produces no commit.
- Window boundary: period 113636+1775 matches la; period 113636+1776 is unknown, so `nota_idx` is unchanged and `locked`=0.
- Alternate periods 151686 and 170264 edge by edge: the candidate never confirms and `nota_idx` holds its previous value.
- Assert `rst` for 1 cycle midway through a mi period: all outputs return to reset values; mi is then re-acquired after 3 rising edges.
